// File: rtl/multi_debounce.sv
// N-channel switch/button debouncer: per-channel synchroniser, lockout or
// stable-window filtering on a tick-qualified counter, registered edge strobes.
module multi_debounce #(
  parameter int unsigned   N           = 4,
  parameter int unsigned   HOLD_CYCLES = 1000000,
  parameter int unsigned   MODE        = 0,
  parameter int unsigned   SYNC_STAGES = 2,
  parameter logic [N-1:0]  RESET_VAL   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] db_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  localparam int unsigned   CW   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   db_q;
    logic                   db_d;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= {SYNC_STAGES{RESET_VAL[i]}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (MODE == 0) begin
        // Lockout: accept immediately when idle, then ignore input until the count drains.
        if (cnt_q == '0) begin
          if (s != db_q) begin
            db_d  = s;
            cnt_d = LAST;
          end
        end else if (tick) begin
          cnt_d = cnt_q - CW'(1);
        end
      end else begin
        // Stable-window: any agreeing cycle restarts the window, tick or not.
        if (s == db_q) begin
          cnt_d = '0;
        end else if (tick) begin
          if (cnt_q == LAST) begin
            db_d  = s;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        db_q   <= RESET_VAL[i];
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        db_q   <= db_d;
        rise_q <= db_d & ~db_q;
        fall_q <= ~db_d & db_q;
      end
    end

    assign db_out[i] = db_q;
    assign rise[i]   = rise_q;
    assign fall[i]   = fall_q;
  end

endmodule

// File: doc/multi_debounce.md
Name: multi_debounce

Overview:
- Parametrised N-channel switch/button debouncer. Successor to the single-channel lockout debouncer.
- Adds per-channel input synchronisation, a selectable filtering mode (lockout or stable-window), a clock-enable tick for long debounce times, and one-cycle rise/fall strobes.
- Sits between raw board buttons/switches and the control FSMs that consume clean levels and edges.

Parameters:
- N, 4, number of independent channels (>=1).
- HOLD_CYCLES, 1000000, debounce period in tick-qualified cycles (>=1).
- MODE, 0, 0 = lockout (fast accept, then ignore input for HOLD_CYCLES); 1 = stable-window (accept only after HOLD_CYCLES consecutive mismatching ticks).
- SYNC_STAGES, 2, flops in each input synchroniser (>=2).
- RESET_VAL, 0, N-bit value loaded into synchronisers and db_out on reset.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  counter enable; tie to 1 to count every clk.
- btn_in  input  N  raw asynchronous inputs.
- db_out  output  N  debounced levels, registered.
- rise  output  N  one-clk strobe, set on the cycle db_out[i] goes 0->1.
- fall  output  N  one-clk strobe, set on the cycle db_out[i] goes 1->0.

Behaviour:
- Reset (asynchronous, while rst_n=0): sync chain[i] = RESET_VAL[i] at every stage; db_out = RESET_VAL; rise = fall = 0; all counters = 0. No strobe fires on reset release.
- Per channel i: s[i] is the last synchroniser stage. A change on btn_in reaches s after SYNC_STAGES edges. Channels are fully independent.
- Counter width is clog2(HOLD_CYCLES+1). No counter wraps: it saturates at its load/limit value by construction.
- MODE 0 (lockout):
  - If cnt==0 and s!=db_out: db_out<=s, cnt<=HOLD_CYCLES-1, strobe fires.
  - If cnt!=0 and tick: cnt<=cnt-1. Input is ignored while cnt!=0.
  - Output changes are spaced at least HOLD_CYCLES ticks apart. Latency from a stable input to db_out is SYNC_STAGES+1 edges when idle.
  - If s returns to the old level during lockout, db_out reflects it on the first cycle after cnt reaches 0.
- MODE 1 (stable-window):
  - s==db_out: cnt<=0, in any cycle, regardless of tick.
  - s!=db_out and tick and cnt==HOLD_CYCLES-1: db_out<=s, cnt<=0, strobe fires.
  - s!=db_out and tick, otherwise: cnt<=cnt+1.
  - s!=db_out and !tick: hold.
  - Latency with tick=1: SYNC_STAGES+HOLD_CYCLES edges. Glitches shorter than HOLD_CYCLES ticks never reach db_out.
- HOLD_CYCLES=1: MODE 0 passes s through with 1 cycle of delay and no lockout. MODE 1 also accepts on the first mismatching tick.
- Strobes:
  - rise[i] = 1 exactly in the cycle where registered db_out[i] first shows 1 after 0; fall[i] is the mirror case.
  - Both are registered, so they are coincident with the db_out change.
  - Never both high on one channel in the same cycle.
- Reset asserted mid-count: counters clear and db_out returns to RESET_VAL immediately, with no strobe.

Test Plan:
- Default config with N=4, HOLD_CYCLES=4, SYNC_STAGES=2, MODE=0, RESET_VAL=0, tick=1:
  - Hold rst_n=0 with btn_in=4'hF, then release -> db_out=0, rise=0 during reset. db_out[3:0]=F appears at edge 3 after release with rise=F for 1 cycle.
  - Channel 0 bounces 0-1-0-1 at 1-cycle intervals, then holds 1 -> db_out[0] rises once at edge 3. It falls on the first eligible cycle (4 edges later) only if s is 0 then, and ends at 1 with exactly one fall/rise pair or none.
- Same config with MODE=1:
  - 3-cycle pulse on btn_in[1] -> db_out[1] stays 0, no strobe.
  - 4-cycle pulse on btn_in[1] -> db_out[1]=1 at edge 6 after the first high sample, rise[1] for 1 cycle; fall[1] follows 4 cycles after the input returns low.
- MODE=1, tick high every 3rd clk, HOLD_CYCLES=4, steady input change -> db_out changes after the 4th tick, about 12 clks after the synchroniser. A mismatch interrupted by one equal cycle restarts the count.
- Channels 0 and 2 change on the same cycle -> both update on the same edge with independent strobes. Channel 1 unaffected.
- Assert rst_n low mid-count in MODE 0 and MODE 1 -> outputs go to RESET_VAL asynchronously (before the next clk edge), strobes 0. After release, the count restarts from 0.
